axi_slave_mem: RTL and testbench

//  AXI4 memory-mapped responder (subordinate) backed by an internal word-addressed RAM.

---
 rtl/axi_slave_mem_if.sv | 69 ++++++
 rtl/axi_slave_mem.sv | 147 ++++++++++++++
 tb/tb_axi_slave_mem.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_mem_if.sv
// AXI4 bus bundle between a single-transaction master and the axi_slave_mem responder.
// Signal names follow the AXI channel names; the master modport drives requests.
interface axi_slave_mem_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned NB = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   AWID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [DATA_WIDTH-1:0] WDATA;
  logic [NB-1:0]         WSTRB;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;

  logic [ID_WIDTH-1:0]   BID;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [ID_WIDTH-1:0]   ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [ID_WIDTH-1:0]   RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi_slave_mem.sv
// AXI4 responder backed by a word-addressed RAM; one INCR burst (write or read) at a time,
// byte strobes on writes, SLVERR for beats that fall outside the RAM window.
module axi_slave_mem #(
  parameter int unsigned          ID_WIDTH   = 4,
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic           ACLK,
  input  logic           ARESETn,
  axi_slave_mem_if.slave bus
);
  localparam int unsigned NB      = DATA_WIDTH / 8;
  localparam int unsigned BYTE_SH = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned MEM_AW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WDAT, WRSP, RDAT} state_t;

  state_t                state, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [MEM_AW-1:0]     mem_idx;
  logic                  in_range;
  logic                  last;
  logic                  mem_we;
  logic                  awready, arready, wready, bvalid, rvalid;

  // Addresses below BASE_ADDR wrap to huge offsets and so land out of range too.
  assign offset   = addr_q - BASE_ADDR;
  assign word_idx = offset >> BYTE_SH;
  assign in_range = word_idx < ADDR_WIDTH'(MEM_DEPTH);
  assign mem_idx  = word_idx[MEM_AW-1:0];
  assign last     = (cnt_q == len_q);

  // State and burst-context registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state  <= IDLE;
      id_q   <= '0;
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_d;
      id_q   <= id_d;
      addr_q <= addr_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Next-state, burst bookkeeping and channel readies/valids
  always_comb begin
    state_d = state;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    awready = 1'b0;
    arready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    rvalid  = 1'b0;
    mem_we  = 1'b0;
    case (state)
      IDLE: begin
        awready = ARESETn;
        arready = ARESETn & ~bus.AWVALID;
        if (bus.AWVALID) begin
          state_d = WDAT;
          id_d    = bus.AWID;
          addr_d  = bus.AWADDR;
          len_d   = bus.AWLEN;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (bus.ARVALID) begin
          state_d = RDAT;
          id_d    = bus.ARID;
          addr_d  = bus.ARADDR;
          len_d   = bus.ARLEN;
          cnt_d   = '0;
        end
      end
      WDAT: begin
        wready = 1'b1;
        if (bus.WVALID) begin
          mem_we = in_range;
          if (!in_range || (bus.WLAST != last)) err_d = 1'b1;
          addr_d = addr_q + ADDR_WIDTH'(NB);
          if (last) state_d = WRSP;
          else      cnt_d   = cnt_q + 8'd1;
        end
      end
      WRSP: begin
        bvalid = 1'b1;
        if (bus.BREADY) state_d = IDLE;
      end
      RDAT: begin
        rvalid = 1'b1;
        if (bus.RREADY) begin
          addr_d = addr_q + ADDR_WIDTH'(NB);
          if (last) state_d = IDLE;
          else      cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM is deliberately outside the reset domain so contents survive ARESETn
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (bus.WSTRB[i]) mem[mem_idx][8*i +: 8] <= bus.WDATA[8*i +: 8];
      end
    end
  end

  // Channel outputs decode the state register, so they read 0 throughout reset
  assign bus.AWREADY = awready;
  assign bus.ARREADY = arready;
  assign bus.WREADY  = wready;
  assign bus.BVALID  = bvalid;
  assign bus.BID     = id_q;
  assign bus.BRESP   = (bvalid && err_q) ? 2'b10 : 2'b00;
  assign bus.RVALID  = rvalid;
  assign bus.RID     = id_q;
  assign bus.RLAST   = rvalid & last;
  assign bus.RRESP   = (rvalid && !in_range) ? 2'b10 : 2'b00;
  assign bus.RDATA   = (rvalid && in_range) ? mem[mem_idx] : '0;

  logic unused_ok;
  assign unused_ok = ^{bus.AWSIZE, bus.AWBURST, bus.ARSIZE, bus.ARBURST};

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: bursts, strobes, tie-break, range errors, stalls, reset.
module tb_axi_slave_mem;
  logic clk;
  logic rst_n;

  axi_slave_mem_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_slave_mem #(
    .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .BASE_ADDR(32'h0)
  ) dut (
    .ACLK   (clk),
    .ARESETn(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] ed [16];
  logic [1:0]  er [16];
  int          early_last = -1;
  time         ar_t, b_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full write burst using wd/ws; BREADY held low for b_stall cycles with BVALID checked each cycle
  task automatic axi_write(input string tag, input logic [3:0] id, input logic [31:0] addr,
                           input int len, input logic [1:0] exp_bresp, input int b_stall);
    int n;
    bus.AWVALID = 1'b1;
    bus.AWID    = id;
    bus.AWADDR  = addr;
    bus.AWLEN   = 8'(len);
    #1;
    n = 0;
    while (!bus.AWREADY && n < 100) begin
      tick();
      n++;
    end
    check($sformatf("%s_awready", tag), 64'(bus.AWREADY), 64'd1);
    tick();
    bus.AWVALID = 1'b0;
    for (int b = 0; b <= len; b++) begin
      bus.WVALID = 1'b1;
      bus.WDATA  = wd[b];
      bus.WSTRB  = ws[b];
      bus.WLAST  = (b == len) || (b == early_last);
      #1;
      check($sformatf("%s_wready%0d", tag, b), 64'(bus.WREADY), 64'd1);
      tick();
    end
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
    for (int s = 0; s <= b_stall; s++) begin
      bus.BREADY = (s == b_stall);
      #1;
      check($sformatf("%s_bvalid%0d", tag, s), 64'(bus.BVALID), 64'd1);
      check($sformatf("%s_bresp%0d", tag, s), 64'(bus.BRESP), 64'(exp_bresp));
      check($sformatf("%s_bid%0d", tag, s), 64'(bus.BID), 64'(id));
      tick();
    end
    b_t = $time;
    bus.BREADY = 1'b0;
    #1;
    check($sformatf("%s_bdone", tag), 64'(bus.BVALID), 64'd0);
  endtask

  // Full read burst checked beat by beat against ed/er; RREADY low for r_stall cycles per beat
  task automatic axi_read(input string tag, input logic [3:0] id, input logic [31:0] addr,
                          input int len, input int r_stall);
    int n;
    bus.ARVALID = 1'b1;
    bus.ARID    = id;
    bus.ARADDR  = addr;
    bus.ARLEN   = 8'(len);
    #1;
    n = 0;
    while (!bus.ARREADY && n < 100) begin
      tick();
      #1;
      n++;
    end
    check($sformatf("%s_arready", tag), 64'(bus.ARREADY), 64'd1);
    ar_t = $time;
    tick();
    bus.ARVALID = 1'b0;
    for (int b = 0; b <= len; b++) begin
      for (int s = 0; s <= r_stall; s++) begin
        bus.RREADY = (s == r_stall);
        #1;
        check($sformatf("%s_rvalid%0d_%0d", tag, b, s), 64'(bus.RVALID), 64'd1);
        check($sformatf("%s_rdata%0d_%0d", tag, b, s), 64'(bus.RDATA), 64'(ed[b]));
        check($sformatf("%s_rresp%0d_%0d", tag, b, s), 64'(bus.RRESP), 64'(er[b]));
        check($sformatf("%s_rlast%0d_%0d", tag, b, s), 64'(bus.RLAST), 64'(b == len));
        check($sformatf("%s_rid%0d_%0d", tag, b, s), 64'(bus.RID), 64'(id));
        tick();
      end
    end
    bus.RREADY = 1'b0;
    #1;
    check($sformatf("%s_rdone", tag), 64'(bus.RVALID), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.AWVALID = 1'b0; bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0;
    bus.AWSIZE = 3'd2;  bus.AWBURST = 2'b01;
    bus.WVALID = 1'b0;  bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
    bus.BREADY = 1'b0;
    bus.ARVALID = 1'b0; bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0;
    bus.ARSIZE = 3'd2;  bus.ARBURST = 2'b01;
    bus.RREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 64'({bus.AWREADY, bus.ARREADY, bus.WREADY, bus.BVALID, bus.BRESP, bus.BID,
                             bus.RVALID, bus.RDATA, bus.RRESP, bus.RLAST, bus.RID}), 64'd0);
    rst_n = 1'b1;
    #1;
    check("idle_ready", 64'({bus.AWREADY, bus.ARREADY, bus.WREADY}), 64'b110);

    // 4-beat burst write then read back
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'(32'hA0 + i); ws[i] = 4'hF; ed[i] = 32'(32'hA0 + i); er[i] = 2'b00;
    end
    axi_write("t1w", 4'h5, 32'h10, 3, 2'b00, 0);
    axi_read("t1r", 4'h9, 32'h10, 3, 0);

    // Byte strobes merge into existing word
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    axi_write("t2a", 4'h1, 32'h20, 0, 2'b00, 0);
    wd[0] = 32'h1234_5678; ws[0] = 4'b0101;
    axi_write("t2b", 4'h2, 32'h20, 0, 2'b00, 0);
    ed[0] = 32'hFF34_FF78; er[0] = 2'b00;
    axi_read("t2r", 4'h3, 32'h20, 0, 0);

    // Simultaneous AW and AR: write must win and finish before AR is taken
    bus.AWVALID = 1'b1; bus.AWID = 4'h2; bus.AWADDR = 32'h40; bus.AWLEN = 8'd0;
    bus.ARVALID = 1'b1; bus.ARID = 4'h3; bus.ARADDR = 32'h40; bus.ARLEN = 8'd0;
    #1;
    check("t3_tie", 64'({bus.AWREADY, bus.ARREADY}), 64'b10);
    wd[0] = 32'hCAFE_F00D; ws[0] = 4'hF; ed[0] = 32'hCAFE_F00D; er[0] = 2'b00;
    fork
      axi_write("t3w", 4'h2, 32'h40, 0, 2'b00, 0);
      axi_read("t3r", 4'h3, 32'h40, 0, 0);
    join
    check("t3_order", 64'(ar_t > b_t), 64'd1);

    // Burst crossing the top of RAM; word 0 must not be hit by the dropped beat
    wd[0] = 32'h55AA_55AA; ws[0] = 4'hF;
    axi_write("t4w0", 4'h4, 32'h0, 0, 2'b00, 0);
    wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222; ws[0] = 4'hF; ws[1] = 4'hF;
    axi_write("t4w", 4'h7, 32'h3FC, 1, 2'b10, 0);
    ed[0] = 32'h1111_1111; er[0] = 2'b00; ed[1] = 32'h0; er[1] = 2'b10;
    axi_read("t4r", 4'h8, 32'h3FC, 1, 0);
    ed[0] = 32'h55AA_55AA; er[0] = 2'b00;
    axi_read("t4r0", 4'h8, 32'h0, 0, 0);

    // Backpressure on B and R
    wd[0] = 32'h0000_0077; wd[1] = 32'h0000_0088; ws[0] = 4'hF; ws[1] = 4'hF;
    axi_write("t5w", 4'hA, 32'h80, 1, 2'b00, 5);
    ed[0] = 32'h0000_0077; ed[1] = 32'h0000_0088; er[0] = 2'b00; er[1] = 2'b00;
    axi_read("t5r", 4'hB, 32'h80, 1, 5);

    // WLAST asserted too early flags SLVERR but data still lands
    wd[0] = 32'h6000_0001; wd[1] = 32'h6000_0002; ws[0] = 4'hF; ws[1] = 4'hF;
    early_last = 0;
    axi_write("t7w", 4'hC, 32'h60, 1, 2'b10, 0);
    early_last = -1;
    ed[0] = 32'h6000_0001; ed[1] = 32'h6000_0002; er[0] = 2'b00; er[1] = 2'b00;
    axi_read("t7r", 4'hD, 32'h60, 1, 0);

    // Reset in the middle of a write burst
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'(i + 1); ws[i] = 4'hF;
    end
    axi_write("t6pre", 4'h1, 32'h100, 3, 2'b00, 0);
    bus.AWVALID = 1'b1; bus.AWID = 4'h6; bus.AWADDR = 32'h100; bus.AWLEN = 8'd3;
    #1;
    check("t6_awready", 64'(bus.AWREADY), 64'd1);
    tick();
    bus.AWVALID = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.WVALID = 1'b1; bus.WDATA = 32'(32'hD1 + b); bus.WSTRB = 4'hF; bus.WLAST = 1'b0;
      #1;
      check($sformatf("t6_wready%0d", b), 64'(bus.WREADY), 64'd1);
      tick();
    end
    bus.WDATA = 32'hD3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_outs", 64'({bus.AWREADY, bus.ARREADY, bus.WREADY, bus.BVALID, bus.BRESP, bus.BID,
                              bus.RVALID, bus.RDATA, bus.RRESP, bus.RLAST, bus.RID}), 64'd0);
    bus.WVALID = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_idle", 64'({bus.AWREADY, bus.ARREADY, bus.WREADY, bus.BVALID}), 64'b1100);
    ed[0] = 32'hD1; ed[1] = 32'hD2; ed[2] = 32'd3; ed[3] = 32'd4;
    for (int i = 0; i < 4; i++) er[i] = 2'b00;
    axi_read("t6r", 4'hE, 32'h100, 3, 0);
    wd[0] = 32'h600D_BEEF; ws[0] = 4'hF;
    axi_write("t6w2", 4'hF, 32'h10C, 0, 2'b00, 0);
    ed[0] = 32'h600D_BEEF; er[0] = 2'b00;
    axi_read("t6r2", 4'h0, 32'h10C, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
